mt_stream_buffer: RTL

// Downstream consumer of the Mersenne-twister core. It paces the core's trig/ready extraction

---
 rtl/mt_stream_buffer_if.sv | 19 +
 rtl/mt_stream_buffer.sv | 96 +++++++++
 2 files changed

// File: rtl/mt_stream_buffer_if.sv
// rtl/mt_stream_buffer_if.sv - generator extraction and output stream signals of the MT stream buffer
interface mt_stream_buffer_if;
  logic        gen_ready;
  logic [31:0] gen_num;
  logic        gen_trig;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;

  modport master (
    input  gen_ready, gen_num, m_ready,
    output gen_trig, m_valid, m_data
  );

  modport slave (
    output gen_ready, gen_num, m_ready,
    input  gen_trig, m_valid, m_data
  );
endinterface

// File: rtl/mt_stream_buffer.sv
// rtl/mt_stream_buffer.sv - paces MT core extraction into a FWFT FIFO driving a valid/ready stream
module mt_stream_buffer #(
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  mt_stream_buffer_if.master       bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         delivered
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, SETTLE} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          fire, push, pop;

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    fire       = 1'b0;
    case (state)
      IDLE:    if (en) state_nxt = WAIT;
      WAIT:    if (bus.gen_ready) state_nxt = CAPTURE;
      CAPTURE: begin
        // Full test uses the registered level, so a same-cycle pop never frees a slot.
        fire = bus.gen_ready && (level < (PW+1)'(DEPTH)) && !flush && en && !rst;
        if (fire) begin
          settle_nxt = SW'(RD_LAT);
          state_nxt  = SETTLE;
        end else if (!bus.gen_ready) begin
          state_nxt = WAIT;
        end else if (!en) begin
          state_nxt = IDLE;
        end
      end
      SETTLE: begin
        // Runs to completion regardless of en/gen_ready so the in-flight read settles.
        settle_nxt = settle_cnt - SW'(1);
        if (settle_cnt == SW'(1)) state_nxt = en ? CAPTURE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  assign push         = fire;
  assign pop          = bus.m_valid && bus.m_ready && !flush;
  assign bus.gen_trig = fire;
  assign bus.m_valid  = (level != '0);
  assign bus.m_data   = bus.m_valid ? mem[rd_ptr] : 32'd0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.gen_num;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      delivered <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        delivered <= delivered + CNT_W'(1);
      end
      if (push && !pop)      level <= level + (PW+1)'(1);
      else if (pop && !push) level <= level - (PW+1)'(1);
    end
  end

endmodule
